// File: rtl/sdp_delay_ram.sv
// sdp_delay_ram: multi-channel sample delay line built on one simple-dual-port
// memory. Each channel owns a circular buffer of DEPTH words. A read fetches
// the sample written rd_delay writes ago. Reads of samples that were never
// written return rd_err with zero data.
// Optional build macro: SDP_DELAY_RAM_OREG_EN adds one output register stage,
// which makes the read latency two cycles.
module sdp_delay_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int CH_N   = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clr,
  input  logic                                         wr_en,
  input  logic [((CH_N > 1) ? $clog2(CH_N) : 1)-1:0]   wr_ch,
  input  logic [DATA_W-1:0]                            wr_data,
  input  logic                                         rd_en,
  input  logic [((CH_N > 1) ? $clog2(CH_N) : 1)-1:0]   rd_ch,
  input  logic [$clog2(DEPTH)-1:0]                     rd_delay,
  output logic                                         rd_valid,
  output logic [DATA_W-1:0]                            rd_data,
  output logic                                         rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [CW:0] CH_LIM = (CW+1)'(CH_N);

  logic [DATA_W-1:0] mem [2**(CW+AW)];
  logic [AW-1:0]     wp  [CH_N];
  logic [AW:0]       fc  [CH_N];

  logic              wr_go;
  logic              rd_go;
  logic [AW-1:0]     rd_ptr;
  logic              rd_miss;
  logic [DATA_W-1:0] mem_q;
  logic              valid1;
  logic              ok1;
  logic              err1;

  // Qualify requests: in-range channel, and no clear or reset this cycle.
  always_comb begin
    wr_go   = rst_n && !clr && wr_en && ({1'b0, wr_ch} < CH_LIM);
    rd_go   = rst_n && !clr && rd_en && ({1'b0, rd_ch} < CH_LIM);
    rd_ptr  = wp[rd_ch] - AW'(1) - rd_delay;
    rd_miss = ({1'b0, rd_delay} >= fc[rd_ch]);
  end

  // Memory array with no reset so it maps onto block RAM; stale words are masked by fc.
  always_ff @(posedge clk) begin
    if (wr_go)
      mem[{wr_ch, wp[wr_ch]}] <= wr_data;
    if (rd_go)
      mem_q <= mem[{rd_ch, rd_ptr}];
  end

  // Per-channel write pointer and saturating fill count.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < CH_N; i++) begin
        wp[i] <= '0;
        fc[i] <= '0;
      end
    end else if (wr_go) begin
      wp[wr_ch] <= wp[wr_ch] + AW'(1);
      if (fc[wr_ch] != FULL)
        fc[wr_ch] <= fc[wr_ch] + (AW+1)'(1);
    end
  end

  // First read stage: strobe plus status; status holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      ok1    <= 1'b0;
      err1   <= 1'b0;
    end else begin
      valid1 <= rd_go;
      if (rd_go) begin
        ok1  <= !rd_miss;
        err1 <= rd_miss;
      end
    end
  end

`ifdef SDP_DELAY_RAM_OREG_EN
  logic              valid2;
  logic [DATA_W-1:0] data2;
  logic              err2;

  // Output register stage: strobe, data and error move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid2 <= 1'b0;
      data2  <= '0;
      err2   <= 1'b0;
    end else if (clr) begin
      valid2 <= 1'b0;
    end else begin
      valid2 <= valid1;
      if (valid1) begin
        data2 <= ok1 ? mem_q : '0;
        err2  <= err1;
      end
    end
  end

  assign rd_valid = valid2;
  assign rd_data  = data2;
  assign rd_err   = err2;
`else
  assign rd_valid = valid1;
  assign rd_data  = ok1 ? mem_q : '0;
  assign rd_err   = err1;
`endif

endmodule

// File: tb/tb_sdp_delay_ram.sv
// tb_sdp_delay_ram: directed scenarios plus randomized traffic, compared
// against a queue-based per-channel history model.
module tb_sdp_delay_ram;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int CH_N   = 4;
  localparam int AW     = 9;
  localparam int CW     = 2;
`ifdef SDP_DELAY_RAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              wr_en;
  logic [CW-1:0]     wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [CW-1:0]     rd_ch;
  logic [AW-1:0]     rd_delay;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  int checks = 0;
  int errors = 0;

  // Model: history of samples per channel, newest at the back, at most DEPTH kept.
  int                hist [CH_N][$];
  logic              pv [LAT];
  logic [DATA_W-1:0] pd [LAT];
  logic              pe [LAT];
  logic [DATA_W-1:0] heldData;
  logic              heldErr;

  sdp_delay_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_N(CH_N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_delay(rd_delay),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic applyStimulus(input logic rstV, input logic clrV, input logic wrV, input int wc,
                               input logic [DATA_W-1:0] wd, input logic rdV, input int rc,
                               input int dly);
    logic              nv;
    logic              ne;
    logic [DATA_W-1:0] nd;
    int                fill;
    @(negedge clk);
    rst_n    = !rstV;
    clr      = clrV;
    wr_en    = wrV;
    wr_ch    = CW'(wc);
    wr_data  = wd;
    rd_en    = rdV;
    rd_ch    = CW'(rc);
    rd_delay = AW'(dly);
    fill = hist[rc].size();
    nv   = rdV;
    ne   = (dly >= fill);
    nd   = ne ? '0 : DATA_W'(hist[rc][fill-1-dly]);
    if (rstV || clrV) begin
      for (int c = 0; c < CH_N; c++) hist[c].delete();
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      if (rstV) begin
        heldData = '0;
        heldErr  = 1'b0;
      end
    end else begin
      if (wrV) begin
        hist[wc].push_back(int'(wd));
        if (hist[wc].size() > DEPTH) void'(hist[wc].pop_front());
      end
      for (int i = LAT-1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
        pe[i] = pe[i-1];
      end
      pv[0] = nv;
      pd[0] = nd;
      pe[0] = ne;
      if (pv[LAT-1]) begin
        heldData = pd[LAT-1];
        heldErr  = pe[LAT-1];
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rd_valid", 32'(rd_valid), 32'(pv[LAT-1]));
    checkOutput("rd_data", 32'(rd_data), 32'(heldData));
    checkOutput("rd_err", 32'(rd_err), 32'(heldErr));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
  endtask

  task automatic writeSample(input int ch, input logic [DATA_W-1:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, ch, d, 1'b0, 0, 0);
  endtask

  // Read with a fixed expected result, checked when the response is due.
  task automatic readCheck(input string tag, input int ch, input int dly,
                           input logic [DATA_W-1:0] expData, input logic expErr);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, ch, dly);
    repeat (LAT-1) idle();
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'(expData));
    checkOutput({tag, "_err"}, 32'(rd_err), 32'(expErr));
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
      pe[i] = 1'b0;
    end
    heldData = '0;
    heldErr  = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
    checkOutput("reset_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_data", 32'(rd_data), 32'd0);

    for (int i = 1; i <= 5; i++) writeSample(2, DATA_W'(i));
    readCheck("ch2_d0", 2, 0, 16'h0005, 1'b0);
    readCheck("ch2_d4", 2, 4, 16'h0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 2, 0);
    repeat (LAT-1) checkOutput("latency_early", 32'(rd_valid), 32'd0);
    if (LAT == 2) idle();
    checkOutput("latency_due", 32'(rd_valid), 32'd1);
    idle();
    checkOutput("strobe_one_cycle", 32'(rd_valid), 32'd0);
    checkOutput("hold_data", 32'(rd_data), 32'h5);

    for (int i = 1; i <= 3; i++) writeSample(1, DATA_W'(16'h10 + i));
    readCheck("ch1_d3_miss", 1, 3, 16'h0000, 1'b1);
    readCheck("ch1_d2", 1, 2, 16'h0011, 1'b0);
    readCheck("ch0_empty", 0, 0, 16'h0000, 1'b1);
    readCheck("ch3_empty", 3, 0, 16'h0000, 1'b1);

    for (int i = 0; i < 4; i++) begin
      writeSample(0, 16'hAAAA);
      writeSample(3, 16'h5555);
    end
    readCheck("ch0_aaaa", 0, 0, 16'hAAAA, 1'b0);
    readCheck("ch3_5555", 3, 0, 16'h5555, 1'b0);

    writeSample(1, 16'h00FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 16'h1234, 1'b1, 1, 0);
    repeat (LAT-1) idle();
    checkOutput("same_cycle_old", 32'(rd_data), 32'h00FF);
    readCheck("same_cycle_new", 1, 0, 16'h1234, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    for (int i = 0; i < 520; i++) writeSample(0, DATA_W'(i));
    readCheck("wrap_d0", 0, 0, 16'h0207, 1'b0);
    readCheck("wrap_d511", 0, 511, 16'h0008, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b1, 0, 0);
    repeat (LAT) idle();
    readCheck("after_clr_ch0", 0, 0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) writeSample(2, 16'h0777);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 2, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    idle();
    for (int i = 0; i < 3; i++) writeSample(2, 16'h0888);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 2, 0);
    checkOutput("rst_kills_valid", 32'(rd_valid), 32'd0);
    idle();
    readCheck("after_rst_ch2", 2, 0, 16'h0000, 1'b1);
    readCheck("after_rst_ch1", 1, 0, 16'h0000, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      int  r;
      int  dly;
      r   = int'($urandom_range(0, 199));
      dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1))
                                        : int'($urandom_range(0, 12));
      applyStimulus(r == 0, r == 1 || r == 2, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, CH_N-1)), DATA_W'($urandom),
                    $urandom_range(0, 2) != 0, int'($urandom_range(0, CH_N-1)), dly);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
